pc_read_responder: RTL and testbench
====================================

// Module: pc_read_responder
// PURPOSE
//  Read-side bus responder for the 4x32b lockable p_c register bank. Accepts read requests
//  (valid/ready), decodes addr_i[8:3], applies per-register read locks and returns data through
//  a DEPTH-entry response FIFO. Entries are zeroed on pop, flush and reset, so no stale secret
//  remains in the read path. Sits between the peripheral bus read channel and the p_c bank.
// PARAMETERS
//  DEPTH   2   response FIFO entries; power of 2, >=2
//  DATA_W  32  data width of p_c registers and rdata_o
// PORTS
//  clk_i        in   1        clock; all logic on posedge
//  rst_i        in   1        synchronous, active-high reset
//  req_i        in   1        read request valid
//  req_ready_o  out  1        request accepted when req_i && req_ready_o
//  addr_i       in   32       read address; only [8:3] decoded
//  rdlk_ctrl_i  in   4        per-register read lock; bit i locks p_c[i]
//  p_c_i        in   4xDATA_W live contents of p_c[0..3]
//  flush_i      in   1        one-cycle pulse: discard queued responses and scrub FIFO
//  rvalid_o     out  1        response valid (FIFO head)
//  rready_i     in   1        response consumed when rvalid_o && rready_i
//  rdata_o      out  DATA_W   response data; 0 whenever rvalid_o=0
//  rerr_o       out  1        response error (locked/unmapped); 0 whenever rvalid_o=0
//  busy_o       out  1        1 while in SCRUB
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): state=RUN, count=0, wr/rd ptrs=0, all entries {data,err}=0;
//    outputs after reset: req_ready_o=1, rvalid_o=0, rdata_o=0, rerr_o=0, busy_o=0.
//  - Decode addr_i[8:3]: 1->p_c[3], 2->p_c[2], 3->p_c[1], 4->p_c[0]; other -> unmapped.
//  - On accept: if unmapped or rdlk_ctrl_i[idx]=1 push {data=0,err=1}; else push {p_c_i[idx],0}.
//    Data and lock sampled at the accept edge; queued entries not re-checked later.
//  - Latency: accepted at edge N -> rvalid_o=1 from cycle after N (1 cycle) if FIFO was empty.
//  - req_ready_o = (state==RUN) && !flush_i && (count<DEPTH); combinational, no dependence on
//    rready_i. Push+pop in same cycle: count unchanged, both ptrs advance (mod DEPTH).
//  - rvalid_o = (state==RUN) && !flush_i && (count>0). rdata_o/rerr_o = head entry, else 0.
//  - Pop: head entry written to 0 on the same edge rd_ptr advances (scrub-on-read).
//  - rvalid_o held with stable rdata_o/rerr_o until handshake; rready_i may be held high.
//  - FSM states RUN, SCRUB:
//    RUN  --flush_i--> SCRUB: count<=0, ptrs<=0, scrub_idx<=0; no push/pop that cycle.
//    SCRUB: each cycle entry[scrub_idx]<=0, scrub_idx++; after entry DEPTH-1 -> RUN.
//    SCRUB lasts exactly DEPTH cycles; busy_o=1, req_ready_o=0, rvalid_o=0 throughout.
//    flush_i during SCRUB: ignored (scrub continues, no restart).
//  - rst_i mid-SCRUB or with FIFO non-empty: immediate reset values, no response emitted.
//  - Full (count=DEPTH): req_ready_o=0; empty: rvalid_o=0. Ptrs wrap mod DEPTH.
// STRUCTURE
//  - pc_rd_pkg: state_e {RUN,SCRUB}; resp_t struct {logic [DATA_W-1:0] data; logic err};
//    localparams for addr decode values (1..4) and NREGS=4; decode function addr->idx/valid.
//  - Sub-module pc_rd_resp_fifo: DEPTH-entry resp_t FIFO with push/pop/clear-entry port and
//    zero-on-pop; top holds FSM, decode, lock check, handshake gating.
// TESTING
//  1 Reset, p_c_i={A5A5A5A5,11111111,22222222,DEADBEEF}, rdlk=0, req addr=0x20 (idx 4)
//    -> next cycle rvalid_o=1, rdata_o=0xA5A5A5A5, rerr_o=0.
//  2 rdlk_ctrl_i=4'b1000, read addr=0x08 -> rdata_o=0, rerr_o=1; addr=0x28 (unmapped) -> rerr_o=1.
//  3 rready_i=0, issue 3 back-to-back reads (0x08,0x10,0x18) -> 2 accepted, req_ready_o=0
//    on 3rd; raise rready_i -> responses 0xDEADBEEF, 0x22222222 in order, then 3rd accepted.
//  4 rready_i=1, continuous reads every cycle -> one response per cycle, count never >1,
//    popped entry reads 0 internally after pop.
//  5 FIFO holding 2 entries, pulse flush_i (with req_i=1 same cycle) -> req not accepted,
//    rvalid_o=0, busy_o=1 for exactly 2 cycles, all entries 0, then RUN with count=0.
//  6 rst_i asserted for 1 cycle while in SCRUB with req pending -> next cycle req_ready_o=1,
//    rvalid_o=0, busy_o=0, rdata_o=0.

Source files
------------

// File: rtl/pc_rd_pkg.sv
// Shared types, address decode constants and the decode helper for the p_c read responder.
package pc_rd_pkg;

   localparam int NREGS      = 4;
   localparam int PKG_DATA_W = 32;

   localparam logic [5:0] ADDR_PC3 = 6'd1;
   localparam logic [5:0] ADDR_PC2 = 6'd2;
   localparam logic [5:0] ADDR_PC1 = 6'd3;
   localparam logic [5:0] ADDR_PC0 = 6'd4;

   typedef enum logic {
      RUN   = 1'b0,
      SCRUB = 1'b1
   } state_e;

   typedef struct packed {
      logic [PKG_DATA_W-1:0] data;
      logic                  err;
   } resp_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } dec_t;

   // Word field addr[8:3] maps to registers in descending order.
   function automatic dec_t decode_addr(input logic [5:0] word);
      dec_t d;
      d.valid = 1'b1;
      d.idx   = 2'd0;
      case (word)
         ADDR_PC3: d.idx = 2'd3;
         ADDR_PC2: d.idx = 2'd2;
         ADDR_PC1: d.idx = 2'd1;
         ADDR_PC0: d.idx = 2'd0;
         default:  d.valid = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/pc_rd_resp_fifo.sv
// Response FIFO with zero-on-pop, single-entry scrub port and a bulk pointer/count clear.
module pc_rd_resp_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 33
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   input  logic                       scrub_we_i,
   input  logic [$clog2(DEPTH)-1:0]   scrub_idx_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] scrub_hit, pop_hit, push_hit;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hit
         assign scrub_hit[gi] = scrub_we_i && (scrub_idx_i == PW'(gi));
         assign pop_hit[gi]   = pop_i && (rd_ptr_q == PW'(gi));
         assign push_hit[gi]  = push_i && (wr_ptr_q == PW'(gi));
      end
   endgenerate

   // Push and pop never target the same entry: that needs full (no push) or empty (no pop).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (scrub_hit[i] || pop_hit[i]) begin
            mem_d[i] = '0;
         end
         if (push_hit[i]) begin
            mem_d[i] = push_data_i;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/pc_read_responder.sv
// Read responder for the lockable p_c bank: decode, lock check, response FIFO and flush scrub FSM.
module pc_read_responder
   import pc_rd_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_i,
   output logic                      req_ready_o,
   input  logic [31:0]               addr_i,
   input  logic [3:0]                rdlk_ctrl_i,
   input  logic [NREGS*DATA_W-1:0]   p_c_i,
   input  logic                      flush_i,
   output logic                      rvalid_o,
   input  logic                      rready_i,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      rerr_o,
   output logic                      busy_o
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;
   localparam int W     = DATA_W + 1;

   state_e           state_q, state_d;
   logic [PW-1:0]    scrub_idx_q, scrub_idx_d;
   logic             fifo_clear, scrub_we;
   logic [W-1:0]     head, push_data;
   logic [CNT_W-1:0] count;
   logic             accept, pop, locked, run_open;
   dec_t             dec;
   logic [DATA_W-1:0] p_c [NREGS];
   logic             unused_addr;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_pc
         assign p_c[gi] = p_c_i[gi*DATA_W +: DATA_W];
      end
   endgenerate

   assign unused_addr = ^{addr_i[31:9], addr_i[2:0]};

   assign dec       = decode_addr(addr_i[8:3]);
   assign locked    = !dec.valid || rdlk_ctrl_i[dec.idx];
   assign push_data = locked ? {{DATA_W{1'b0}}, 1'b1} : {p_c[dec.idx], 1'b0};

   assign run_open    = (state_q == RUN) && !flush_i;
   assign req_ready_o = run_open && (count < CNT_W'(DEPTH));
   assign rvalid_o    = run_open && (count != '0);
   assign accept      = req_i && req_ready_o;
   assign pop         = rvalid_o && rready_i;

   assign rdata_o = rvalid_o ? head[W-1:1] : '0;
   assign rerr_o  = rvalid_o && head[0];

   always_comb begin
      state_d     = state_q;
      scrub_idx_d = scrub_idx_q;
      fifo_clear  = 1'b0;
      scrub_we    = 1'b0;
      busy_o      = 1'b0;
      case (state_q)
         RUN: begin
            if (flush_i) begin
               state_d     = SCRUB;
               scrub_idx_d = '0;
               fifo_clear  = 1'b1;
            end
         end
         SCRUB: begin
            busy_o      = 1'b1;
            scrub_we    = 1'b1;
            scrub_idx_d = scrub_idx_q + 1'b1;
            if (scrub_idx_q == PW'(DEPTH - 1)) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         scrub_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         scrub_idx_q <= scrub_idx_d;
      end
   end

   pc_rd_resp_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (fifo_clear),
      .push_i      (accept),
      .push_data_i (push_data),
      .pop_i       (pop),
      .scrub_we_i  (scrub_we),
      .scrub_idx_i (scrub_idx_q),
      .head_o      (head),
      .count_o     (count)
   );

endmodule

// File: tb/tb_pc_read_responder.sv
// Scoreboard bench for pc_read_responder: directed scenarios followed by randomized traffic.
module tb_pc_read_responder;

   localparam int DEPTH = 2;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         req_i;
   logic         req_ready_o;
   logic [31:0]  addr_i;
   logic [3:0]   rdlk_ctrl_i;
   logic [127:0] p_c_i;
   logic         flush_i;
   logic         rvalid_o;
   logic         rready_i;
   logic [31:0]  rdata_o;
   logic         rerr_o;
   logic         busy_o;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];
   int          scrub_left = 0;

   always #5 clk_i = ~clk_i;

   pc_read_responder #(.DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .req_ready_o (req_ready_o),
      .addr_i      (addr_i),
      .rdlk_ctrl_i (rdlk_ctrl_i),
      .p_c_i       (p_c_i),
      .flush_i     (flush_i),
      .rvalid_o    (rvalid_o),
      .rready_i    (rready_i),
      .rdata_o     (rdata_o),
      .rerr_o      (rerr_o),
      .busy_o      (busy_o)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference response {data, err}: word 1..4 selects p_c[3..0]; locked or unknown words error.
   function automatic logic [32:0] exp_resp(input logic [31:0] a, input logic [3:0] lk,
                                            input logic [127:0] pc);
      int r;
      case (a[8:3])
         6'd1:    r = 3;
         6'd2:    r = 2;
         6'd3:    r = 1;
         6'd4:    r = 0;
         default: r = -1;
      endcase
      if (r < 0) return {32'h0, 1'b1};
      if (lk[r]) return {32'h0, 1'b1};
      return {pc[r*32 +: 32], 1'b0};
   endfunction

   always @(negedge clk_i) begin : mon
      logic exp_busy, exp_rdy, exp_rv;
      logic [32:0] h;
      exp_busy = (scrub_left > 0);
      exp_rdy  = !exp_busy && !flush_i && (exp_q.size() < DEPTH);
      exp_rv   = !exp_busy && !flush_i && (exp_q.size() > 0);
      chk("busy", busy_o, exp_busy);
      chk("req_ready", req_ready_o, exp_rdy);
      chk("rvalid", rvalid_o, exp_rv);
      if (exp_rv) begin
         h = exp_q[0];
         chk("rdata", rdata_o, h[32:1]);
         chk("rerr", rerr_o, h[0]);
      end else begin
         chk("rdata_idle", rdata_o, 0);
         chk("rerr_idle", rerr_o, 0);
      end
      if (rst_i) begin
         exp_q.delete();
         scrub_left = 0;
      end else if (scrub_left > 0) begin
         scrub_left--;
      end else if (flush_i) begin
         exp_q.delete();
         scrub_left = DEPTH;
      end else begin
         if (exp_rv && rready_i) begin
            h = exp_q.pop_front();
            $display("RESP data=%08h err=%0b t=%0t", h[32:1], h[0], $time);
         end
         if (exp_rdy && req_i) begin
            exp_q.push_back(exp_resp(addr_i, rdlk_ctrl_i, p_c_i));
         end
      end
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Hold a request until accepted, bounded.
   task automatic send(input logic [31:0] a);
      logic acc;
      req_i  = 1'b1;
      addr_i = a;
      acc    = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) begin
         #1;
         acc = req_ready_o;
         cyc();
      end
      if (!acc) chk("send_timeout", 0, 1);
      req_i = 1'b0;
   endtask

   initial begin
      logic [31:0] addrs [6];
      addrs[0] = 32'h08; addrs[1] = 32'h10; addrs[2] = 32'h18;
      addrs[3] = 32'h20; addrs[4] = 32'h28; addrs[5] = 32'h00;

      rst_i = 1'b1; req_i = 1'b0; addr_i = '0; rdlk_ctrl_i = '0; flush_i = 1'b0;
      rready_i = 1'b1;
      p_c_i = {32'hDEADBEEF, 32'h22222222, 32'h11111111, 32'hA5A5A5A5};
      cyc(); cyc();
      rst_i = 1'b0;
      cyc();

      send(32'h20);
      cyc(); cyc();

      rdlk_ctrl_i = 4'b1000;
      send(32'h08);
      send(32'h28);
      cyc(); cyc();
      rdlk_ctrl_i = 4'b0000;

      rready_i = 1'b0;
      fork
         begin
            send(32'h08);
            send(32'h10);
            send(32'h18);
         end
         begin
            repeat (5) cyc();
            rready_i = 1'b1;
         end
      join
      repeat (3) cyc();

      for (int i = 0; i < 20; i++) send(addrs[i % 4]);
      repeat (3) cyc();

      rready_i = 1'b0;
      send(32'h08);
      send(32'h20);
      flush_i = 1'b1; req_i = 1'b1; addr_i = 32'h10;
      cyc();
      flush_i = 1'b0; req_i = 1'b0;
      repeat (DEPTH) cyc();
      for (int i = 0; i < DEPTH; i++) chk("scrub_mem", dut.u_fifo.mem_q[i], 0);
      cyc();

      send(32'h18);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      rst_i = 1'b1; req_i = 1'b1; addr_i = 32'h08;
      cyc();
      rst_i = 1'b0; req_i = 1'b0;
      repeat (2) cyc();
      rready_i = 1'b1;

      for (int n = 0; n < 800; n++) begin
         req_i       = $urandom_range(0, 3) != 0;
         addr_i      = ($urandom_range(0, 7) == 7) ? $urandom : addrs[$urandom_range(0, 5)];
         rdlk_ctrl_i = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 9) == 0) p_c_i = {$urandom, $urandom, $urandom, $urandom};
         rready_i    = $urandom_range(0, 2) != 0;
         flush_i     = $urandom_range(0, 39) == 0;
         rst_i       = $urandom_range(0, 199) == 0;
         cyc();
      end

      req_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0; rready_i = 1'b1;
      for (int k = 0; k < 20 && (exp_q.size() != 0 || scrub_left != 0); k++) cyc();
      cyc();
      chk("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
